// File: rtl/regfile_pkg.sv
// Shared defaults, FSM encoding and address helper for regfile_mp_sb.
package regfile_pkg;

  localparam int unsigned DEF_REG_DEPTH   = 32;
  localparam int unsigned DEF_REG_WIDTH   = 32;
  localparam int unsigned DEF_RADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_RD      = 2;

  localparam int unsigned ZERO_ADDR = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // x0 and anything past the implemented depth behave as a hardwired zero.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return (addr != ZERO_ADDR) && (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: issue sets, writeback clears, set wins on a tie.
// BYPASS makes a read of the address being written report the post-edge bit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REG_DEPTH   = DEF_REG_DEPTH,
  parameter int unsigned RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter int unsigned NUM_RD      = DEF_NUM_RD,
  parameter bit          BYPASS      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          set_i,
  input  logic [RADDR_WIDTH-1:0]        set_addr_i,
  input  logic                          clr_i,
  input  logic [RADDR_WIDTH-1:0]        clr_addr_i,
  input  logic [NUM_RD*RADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]             busy_o
);

  localparam int unsigned IDXW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic [REG_DEPTH-1:0]   pend_q, pend_d;
  logic [NUM_RD-1:0]      busy_q, busy_d;
  logic [RADDR_WIDTH-1:0] ra;
  logic                   set_ok, clr_ok;

  always_comb begin
    set_ok = en_i && set_i && addr_ok(32'(set_addr_i), REG_DEPTH);
    clr_ok = en_i && clr_i && addr_ok(32'(clr_addr_i), REG_DEPTH);
    pend_d = pend_q;
    if (clr_ok) pend_d[IDXW'(clr_addr_i)] = 1'b0;
    if (set_ok) pend_d[IDXW'(set_addr_i)] = 1'b1;
  end

  always_comb begin
    busy_d = '0;
    ra     = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rd_addr_i[k*RADDR_WIDTH +: RADDR_WIDTH];
      if (en_i && addr_ok(32'(ra), REG_DEPTH)) begin
        if (BYPASS && clr_ok && (ra == clr_addr_i))
          busy_d[k] = set_ok && (set_addr_i == ra);
        else
          busy_d[k] = pend_q[IDXW'(ra)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with pending scoreboard and post-reset clear FSM.
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned REG_DEPTH   = DEF_REG_DEPTH,
  parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
  parameter int unsigned RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter int unsigned NUM_RD      = DEF_NUM_RD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          ready,
  input  logic                          we,
  input  logic [RADDR_WIDTH-1:0]        wr_addr,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic                          iss_valid,
  input  logic [RADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_RD*RADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_busy
);

  localparam int unsigned IDXW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  state_e                 state_q;
  logic [RADDR_WIDTH-1:0] idx_q;
  logic                   ready_q;

  logic [REG_WIDTH-1:0]   bank_q [REG_DEPTH];
  logic                   bank_we;
  logic [IDXW-1:0]        bank_waddr;
  logic [REG_WIDTH-1:0]   bank_wdata;
  logic                   wr_hit;

  logic [REG_WIDTH-1:0]   rdata_q [NUM_RD];
  logic [REG_WIDTH-1:0]   rdata_d [NUM_RD];
  logic [RADDR_WIDTH-1:0] ra;

  // Clear sequencer: one entry per cycle, then RUN until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == RADDR_WIDTH'(REG_DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  assign ready = ready_q;

  always_comb begin
    wr_hit = (state_q == RUN) && we && addr_ok(32'(wr_addr), REG_DEPTH);
    if (state_q == INIT) begin
      bank_we    = 1'b1;
      bank_waddr = IDXW'(idx_q);
      bank_wdata = '0;
    end else begin
      bank_we    = wr_hit;
      bank_waddr = IDXW'(wr_addr);
      bank_wdata = wr_data;
    end
  end

  // No reset on the array so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (bank_we) bank_q[bank_waddr] <= bank_wdata;
  end

  always_comb begin
    ra = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rdata_d[k] = '0;
      ra = rd_addr[k*RADDR_WIDTH +: RADDR_WIDTH];
      if ((state_q == RUN) && addr_ok(32'(ra), REG_DEPTH))
        rdata_d[k] = (BYPASS && wr_hit && (wr_addr == ra)) ? wr_data : bank_q[IDXW'(ra)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_RD; k++) rdata_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_RD; k++) rdata_q[k] <= rdata_d[k];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) rd_data[k*REG_WIDTH +: REG_WIDTH] = rdata_q[k];
  end

  regfile_scoreboard #(
    .REG_DEPTH  (REG_DEPTH),
    .RADDR_WIDTH(RADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == RUN),
    .set_i     (iss_valid),
    .set_addr_i(iss_addr),
    .clr_i     (we),
    .clr_addr_i(wr_addr),
    .rd_addr_i (rd_addr),
    .busy_o    (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a 32-entry and a 16-entry instance share one stimulus
// stream and are compared against an array/counter reference model every cycle.
module tb_regfile_mp_sb;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] iss_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;

  logic             ready_a, ready_b;
  logic [NR*W-1:0]  rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_busy_a, rd_busy_b;

  always #5 clk = ~clk;

  regfile_mp_sb #(.REG_DEPTH(32), .REG_WIDTH(W), .RADDR_WIDTH(AW), .NUM_RD(NR)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a)
  );

  regfile_mp_sb #(.REG_DEPTH(16), .REG_WIDTH(W), .RADDR_WIDTH(AW), .NUM_RD(NR)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b)
  );

  // Reference state: architectural contents, pending flags, cycles since reset release.
  logic [W-1:0] m_bank [2][32];
  bit           m_pend [2][32];
  int unsigned  m_cnt  [2];
  logic [W-1:0] e_data [2][NR];
  bit           e_busy [2][NR];
  bit           e_ready[2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned depth_of(input int n);
    return (n == 0) ? 32 : 16;
  endfunction

  function automatic bit in_range(input int n, input int unsigned a);
    return (a != 0) && (a < depth_of(n));
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_cnt[n]   = 0;
      e_ready[n] = 1'b0;
      // Contents once the post-reset clear has run: everything zero, nothing pending.
      for (int i = 0; i < 32; i++) begin
        m_bank[n][i] = '0;
        m_pend[n][i] = 1'b0;
      end
      for (int k = 0; k < NR; k++) begin
        e_data[n][k] = '0;
        e_busy[n][k] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    int unsigned a;
    for (int n = 0; n < 2; n++) begin
      if (m_cnt[n] < depth_of(n)) begin
        m_cnt[n]++;
        e_ready[n] = (m_cnt[n] >= depth_of(n));
        for (int k = 0; k < NR; k++) begin
          e_data[n][k] = '0;
          e_busy[n][k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < NR; k++) begin
          a = 32'(rd_addr[k*AW +: AW]);
          if (!in_range(n, a)) begin
            e_data[n][k] = '0;
            e_busy[n][k] = 1'b0;
          end else if (BYP && we && (32'(wr_addr) == a)) begin
            e_data[n][k] = wr_data;
            e_busy[n][k] = iss_valid && (32'(iss_addr) == a);
          end else begin
            e_data[n][k] = m_bank[n][a];
            e_busy[n][k] = m_pend[n][a];
          end
        end
        if (we && in_range(n, 32'(wr_addr))) begin
          m_bank[n][wr_addr] = wr_data;
          m_pend[n][wr_addr] = 1'b0;
        end
        if (iss_valid && in_range(n, 32'(iss_addr))) m_pend[n][iss_addr] = 1'b1;
      end
    end
  endtask

  function automatic logic [W-1:0] got_data(input int n, input int k);
    return (n == 0) ? rd_data_a[k*W +: W] : rd_data_b[k*W +: W];
  endfunction

  function automatic logic got_busy(input int n, input int k);
    return (n == 0) ? rd_busy_a[k] : rd_busy_b[k];
  endfunction

  task automatic check_outputs();
    for (int n = 0; n < 2; n++) begin
      check_eq($sformatf("ready[d%0d]", depth_of(n)),
               32'((n == 0) ? ready_a : ready_b), 32'(e_ready[n]));
      for (int k = 0; k < NR; k++) begin
        check_eq($sformatf("rd_data[d%0d][%0d]", depth_of(n), k), got_data(n, k), e_data[n][k]);
        check_eq($sformatf("rd_busy[d%0d][%0d]", depth_of(n), k),
                 32'(got_busy(n, k)), 32'(e_busy[n][k]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1 check_outputs();
  endtask

  task automatic drive(input int unsigned w_en, input int unsigned wa, input int unsigned wd,
                       input int unsigned iv, input int unsigned ia,
                       input int unsigned r0, input int unsigned r1);
    we        = w_en[0];
    wr_addr   = AW'(wa);
    wr_data   = wd;
    iss_valid = iv[0];
    iss_addr  = AW'(ia);
    rd_addr   = {AW'(r1), AW'(r0)};
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
  endtask

  initial begin
    int unsigned wa;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    rst_n = 1'b1;

    // Clear phase: writes and issues to x5 must be ignored; ready timing tracked per depth.
    for (int c = 0; c < 34; c++) begin
      if (c < 8) drive(1, 5, 32'hCAFE0000 + c, 1, 5, 5, 5);
      else       drive(0, 0, 0, 0, 0, 5, 0);
      cycle();
    end

    drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);  cycle();
    drive(0, 0, 0, 0, 0, 3, 3);             cycle();
    drive(1, 0, 32'h1234, 0, 0, 0, 0);      cycle();
    drive(0, 0, 0, 0, 0, 0, 0);             cycle();

    drive(1, 7, 32'h11, 0, 0, 0, 0);        cycle();
    drive(1, 7, 32'h22, 0, 0, 7, 7);        cycle();
    drive(0, 0, 0, 0, 0, 7, 7);             cycle();

    drive(0, 0, 0, 1, 9, 0, 0);             cycle();
    drive(0, 0, 0, 0, 0, 9, 9);             cycle();
    drive(1, 9, 32'h99, 0, 0, 9, 0);        cycle();
    drive(0, 0, 0, 0, 0, 9, 9);             cycle();
    drive(1, 9, 32'h98, 1, 9, 9, 9);        cycle();
    drive(0, 0, 0, 0, 0, 9, 9);             cycle();
    drive(0, 0, 0, 1, 0, 0, 0);             cycle();
    drive(0, 0, 0, 0, 0, 0, 9);             cycle();

    drive(1, 20, 32'hFF, 1, 20, 0, 0);      cycle();
    drive(0, 0, 0, 0, 0, 20, 20);           cycle();

    drive(1, 4, 32'hA5A5A5A5, 0, 0, 0, 0);  cycle();
    drive(0, 0, 0, 1, 6, 4, 0);             cycle();
    drive(0, 0, 0, 0, 0, 4, 6);
    assert_reset();
    cycle();
    rst_n = 1'b1;
    repeat (34) cycle();

    for (int c = 0; c < 600; c++) begin
      wa = $urandom_range(0, 23);
      drive($urandom_range(0, 1), wa, $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 23),
            ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 23),
            $urandom_range(0, 23));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
